// File: rtl/dff_pkg.sv
// dff_pkg: shared constants and helpers for the dff_pipe delay line.
// Holds the default geometry, the default reset value and the fill
// counter width function used by the top-level port list.
package dff_pkg;

    localparam int          DFF_DEFAULT_WIDTH     = 8;
    localparam int          DFF_DEFAULT_DEPTH     = 4;
    localparam logic [63:0] DFF_DEFAULT_RESET_VAL = 64'h0;

    // Width of a counter that must represent 0..depth inclusive.
    function automatic int DFF_FILL_W(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage : dff_pkg

// File: rtl/dff_stage.sv
// dff_stage: one pipeline slot of dff_pipe -- a WIDTH-bit data register plus
// its valid bit. Asynchronous active-low reset, synchronous clear (which
// beats enable), and enable; with enable low the slot holds its contents.
module dff_stage
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DFF_DEFAULT_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DFF_DEFAULT_RESET_VAL)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             vld_i,
    output logic [WIDTH-1:0] data_o,
    output logic             vld_o
);

    logic [WIDTH-1:0] data_q;
    logic [WIDTH-1:0] data_d;
    logic             vld_q;
    logic             vld_d;

    // Next-state selection: clear first, then load on enable, otherwise hold.
    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (clr_i) begin
            data_d = RESET_VAL;
            vld_d  = 1'b0;
        end else if (en_i) begin
            data_d = data_i;
            vld_d  = vld_i;
        end else begin
            data_d = data_q;
            vld_d  = vld_q;
        end
    end

    // Slot state register with asynchronous reset to the idle value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= RESET_VAL;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign data_o = data_q;
    assign vld_o  = vld_q;

endmodule : dff_stage

// File: rtl/dff_pipe.sv
// dff_pipe: WIDTH-bit, DEPTH-stage registered delay line with stall (en),
// synchronous flush, per-stage valid tracking and a registered fill count.
// Priority per edge: reset > flush > en > hold. All outputs come straight
// from registers, so there is no combinational input-to-output path.
// Optional build macro DFF_PIPE_TAP_EN exposes every stage (taps) and every
// valid bit (tap_vld) as extra outputs; without it those ports do not exist.
module dff_pipe
    import dff_pkg::*;
#(
    parameter int               WIDTH     = DFF_DEFAULT_WIDTH,
    parameter int               DEPTH     = DFF_DEFAULT_DEPTH,
    parameter logic [WIDTH-1:0] RESET_VAL = WIDTH'(DFF_DEFAULT_RESET_VAL)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          en,
    input  logic                          flush,
    input  logic [WIDTH-1:0]              d,
    input  logic                          d_vld,
    output logic [WIDTH-1:0]              q,
    output logic                          q_vld,
    output logic [DFF_FILL_W(DEPTH)-1:0]  fill
`ifdef DFF_PIPE_TAP_EN
    ,
    output logic [WIDTH*DEPTH-1:0]        taps,
    output logic [DEPTH-1:0]              tap_vld
`endif
);

    localparam int FW = DFF_FILL_W(DEPTH);

    logic [WIDTH-1:0] stage_data [DEPTH];
    logic [DEPTH-1:0] stage_vld;

    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_d;

    // Chain of stages: stage 0 takes the pipe input, stage i takes stage i-1.
    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [WIDTH-1:0] data_in;
        logic             vld_in;

        if (i == 0) begin : g_head
            assign data_in = d;
            assign vld_in  = d_vld;
        end else begin : g_link
            assign data_in = stage_data[i-1];
            assign vld_in  = stage_vld[i-1];
        end

        dff_stage #(
            .WIDTH     (WIDTH),
            .RESET_VAL (RESET_VAL)
        ) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .clr_i  (flush),
            .en_i   (en),
            .data_i (data_in),
            .vld_i  (vld_in),
            .data_o (stage_data[i]),
            .vld_o  (stage_vld[i])
        );
    end

    // Fill tracking: +1 when a valid word enters, -1 when one leaves the last
    // stage, both only on enabled edges; a simultaneous entry and exit cancel.
    // Modular arithmetic is safe because fill always equals popcount(vld).
    always_comb begin
        fill_d = fill_q;
        if (flush) begin
            fill_d = {FW{1'b0}};
        end else if (en) begin
            fill_d = fill_q + FW'(d_vld) - FW'(stage_vld[DEPTH-1]);
        end else begin
            fill_d = fill_q;
        end
    end

    // Fill counter register with asynchronous reset to empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fill_q <= {FW{1'b0}};
        end else begin
            fill_q <= fill_d;
        end
    end

    assign q     = stage_data[DEPTH-1];
    assign q_vld = stage_vld[DEPTH-1];
    assign fill  = fill_q;

`ifdef DFF_PIPE_TAP_EN
    // Raw fan-out of every stage register, stage 0 in the low slice.
    for (genvar t = 0; t < DEPTH; t++) begin : g_tap
        assign taps[t*WIDTH +: WIDTH] = stage_data[t];
    end
    assign tap_vld = stage_vld;
`endif

endmodule : dff_pipe

// File: tb/tb_dff_pipe.sv
// Self-checking bench for dff_pipe: a WIDTH=8/DEPTH=4 instance checked by an
// age-tracking scoreboard on every edge plus scenario checks, and a DEPTH=1
// instance sharing the same inputs.
`timescale 1ns/1ps
module tb_dff_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    typedef struct {
        logic [WIDTH-1:0] data;
        int               age;
    } item_t;

    logic             clk;
    logic             rst_n;
    logic             en;
    logic             flush;
    logic [WIDTH-1:0] d;
    logic             d_vld;

    logic [WIDTH-1:0] q;
    logic             q_vld;
    logic [2:0]       fill;
    logic [WIDTH-1:0] q1;
    logic             q_vld1;
    logic [0:0]       fill1;
`ifdef DFF_PIPE_TAP_EN
    logic [WIDTH*DEPTH-1:0] taps_a;
    logic [DEPTH-1:0]       tap_vld_a;
    logic [WIDTH-1:0]       taps_b;
    logic [0:0]             tap_vld_b;
`endif

    item_t sb[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    dff_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH), .RESET_VAL(8'h00)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .flush (flush),
        .d     (d),
        .d_vld (d_vld),
        .q     (q),
        .q_vld (q_vld),
        .fill  (fill)
`ifdef DFF_PIPE_TAP_EN
        ,
        .taps    (taps_a),
        .tap_vld (tap_vld_a)
`endif
    );

    dff_pipe #(.WIDTH(WIDTH), .DEPTH(1), .RESET_VAL(8'h00)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .flush (flush),
        .d     (d),
        .d_vld (d_vld),
        .q     (q1),
        .q_vld (q_vld1),
        .fill  (fill1)
`ifdef DFF_PIPE_TAP_EN
        ,
        .taps    (taps_b),
        .tap_vld (tap_vld_b)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, advance the scoreboard, compare the DEPTH=4 outputs.
    task automatic tick(input logic en_v, input logic fl_v,
                        input logic [WIDTH-1:0] d_v, input logic dv_v);
        logic exp_vld;
        en    = en_v;
        flush = fl_v;
        d     = d_v;
        d_vld = dv_v;
        @(posedge clk);
        #1;
        if (fl_v) begin
            sb.delete();
        end else if (en_v) begin
            foreach (sb[i]) sb[i].age = sb[i].age + 1;
            if (sb.size() > 0 && sb[0].age > DEPTH) void'(sb.pop_front());
            if (dv_v) sb.push_back('{data: d_v, age: 1});
        end
        exp_vld = (sb.size() > 0) && (sb[0].age == DEPTH);
        n_checks++;
        if (q_vld !== exp_vld) begin
            n_fail++;
            $display("FAIL sb_q_vld t=%0t got=%b exp=%b", $time, q_vld, exp_vld);
        end
        if (exp_vld) begin
            n_checks++;
            if (q !== sb[0].data) begin
                n_fail++;
                $display("FAIL sb_q t=%0t got=%h exp=%h", $time, q, sb[0].data);
            end
        end
        n_checks++;
        if (fill !== 3'(sb.size())) begin
            n_fail++;
            $display("FAIL sb_fill t=%0t got=%0d exp=%0d", $time, fill, sb.size());
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; flush = 1'b0; d = 8'h00; d_vld = 1'b0;
        sb.delete();
        #1;
        n_checks++;
        if (q !== 8'h00 || q_vld !== 1'b0 || fill !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_a got q=%h v=%b f=%0d exp q=00 v=0 f=0", q, q_vld, fill);
        end
        n_checks++;
        if (q1 !== 8'h00 || q_vld1 !== 1'b0 || fill1 !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_b got q=%h v=%b f=%0d exp q=00 v=0 f=0", q1, q_vld1, fill1);
        end
        #11;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_stream();
        logic [2:0] exp_fill [8] = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4};
        for (int i = 0; i < 8; i++) begin
            tick(1'b1, 1'b0, 8'(i + 1), 1'b1);
            n_checks++;
            if (fill !== exp_fill[i]) begin
                n_fail++;
                $display("FAIL stream_fill i=%0d got=%0d exp=%0d", i, fill, exp_fill[i]);
            end
            if (i == 3) begin
                n_checks++;
                if (q !== 8'h01 || q_vld !== 1'b1) begin
                    n_fail++;
                    $display("FAIL stream_first got q=%h v=%b exp q=01 v=1", q, q_vld);
                end
            end
        end
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_stall();
        logic [WIDTH-1:0] q_hold;
        tick(1'b1, 1'b0, 8'hA1, 1'b1);
        tick(1'b1, 1'b0, 8'hA2, 1'b1);
        q_hold = q;
        for (int i = 0; i < 5; i++) begin
            tick(1'b0, 1'b0, 8'hEE, 1'b1);
            n_checks++;
            if (fill !== 3'd2 || q !== q_hold || q_vld !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold i=%0d got q=%h v=%b f=%0d exp q=%h v=0 f=2",
                         i, q, q_vld, fill, q_hold);
            end
        end
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        n_checks++;
        if (q_vld !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_early got v=%b exp v=0", q_vld);
        end
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        n_checks++;
        if (q !== 8'hA1 || q_vld !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_resume got q=%h v=%b exp q=a1 v=1", q, q_vld);
        end
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_bubbles();
        logic [3:0] pattern;
        int         max_fill;
        logic [3:0] in_vld = 4'b0101;
        max_fill = 0;
        pattern  = 4'b0000;
        for (int j = 0; j < 8; j++) begin
            tick(1'b1, 1'b0, 8'(8'hB0 + j), (j < 4) ? in_vld[j] : 1'b0);
            if (int'(fill) > max_fill) max_fill = int'(fill);
            if (j >= 3 && j <= 6) pattern[j-3] = q_vld;
        end
        n_checks++;
        if (pattern !== 4'b0101) begin
            n_fail++;
            $display("FAIL bubble_pattern got=%b exp=0101 (lsb first)", pattern);
        end
        n_checks++;
        if (max_fill > 2) begin
            n_fail++;
            $display("FAIL bubble_fill got max=%0d exp<=2", max_fill);
        end
    endtask

    task automatic test_flush();
        logic seen_ff;
        seen_ff = 1'b0;
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 8'(8'hC0 + i), 1'b1);
        n_checks++;
        if (fill !== 3'd4) begin
            n_fail++;
            $display("FAIL flush_full got f=%0d exp f=4", fill);
        end
        tick(1'b1, 1'b1, 8'hFF, 1'b1);
        n_checks++;
        if (fill !== 3'd0 || q_vld !== 1'b0 || q !== 8'h00) begin
            n_fail++;
            $display("FAIL flush_clear got q=%h v=%b f=%0d exp q=00 v=0 f=0", q, q_vld, fill);
        end
        for (int i = 0; i < 6; i++) begin
            tick(1'b1, 1'b0, 8'h00, 1'b0);
            if (q === 8'hFF || q_vld !== 1'b0) seen_ff = 1'b1;
        end
        n_checks++;
        if (seen_ff !== 1'b0) begin
            n_fail++;
            $display("FAIL flush_leak got leak=%b exp leak=0", seen_ff);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 4; i++) tick(1'b1, 1'b0, 8'(8'hD0 + i), 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (q !== 8'h00 || q_vld !== 1'b0 || fill !== 3'd0) begin
            n_fail++;
            $display("FAIL async_reset got q=%h v=%b f=%0d exp q=00 v=0 f=0", q, q_vld, fill);
        end
        #2;
        rst_n = 1'b1;
        sb.delete();
        tick(1'b0, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic test_depth1();
        tick(1'b1, 1'b1, 8'h00, 1'b0);
        tick(1'b1, 1'b0, 8'h5A, 1'b1);
        n_checks++;
        if (q1 !== 8'h5A || q_vld1 !== 1'b1 || fill1 !== 1'b1) begin
            n_fail++;
            $display("FAIL d1_load got q=%h v=%b f=%0d exp q=5a v=1 f=1", q1, q_vld1, fill1);
        end
`ifdef DFF_PIPE_TAP_EN
        n_checks++;
        if (taps_b !== 8'h5A || tap_vld_b !== 1'b1) begin
            n_fail++;
            $display("FAIL d1_taps got taps=%h tv=%b exp taps=5a tv=1", taps_b, tap_vld_b);
        end
`endif
        tick(1'b0, 1'b0, 8'h33, 1'b1);
        n_checks++;
        if (q1 !== 8'h5A || q_vld1 !== 1'b1 || fill1 !== 1'b1) begin
            n_fail++;
            $display("FAIL d1_hold got q=%h v=%b f=%0d exp q=5a v=1 f=1", q1, q_vld1, fill1);
        end
        tick(1'b1, 1'b0, 8'h77, 1'b1);
        n_checks++;
        if (q1 !== 8'h77 || q_vld1 !== 1'b1 || fill1 !== 1'b1) begin
            n_fail++;
            $display("FAIL d1_swap got q=%h v=%b f=%0d exp q=77 v=1 f=1", q1, q_vld1, fill1);
        end
        tick(1'b1, 1'b0, 8'h00, 1'b0);
        n_checks++;
        if (q_vld1 !== 1'b0 || fill1 !== 1'b0) begin
            n_fail++;
            $display("FAIL d1_drain got v=%b f=%0d exp v=0 f=0", q_vld1, fill1);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_bubbles();
        test_flush();
        test_async_reset();
        test_depth1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_dff_pipe
